// File: rtl/color_sched_pkg.sv
// -----------------------------------------------------------------------------
// color_sched_pkg
//   Shared types and helpers for the colour-frame sequencer.
//   - state_t      : sequencer states
//   - SEP_LAT_DEF  : default separator latency (input to pixqtd update)
//   - frame_pix()  : pixels per frame from the resolution
//   - cnt_width()  : minimum counter width able to index 0..n-1
// -----------------------------------------------------------------------------
package color_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4,
    REPORT  = 3'd5
  } state_t;

  localparam int SEP_LAT_DEF = 2;

  function automatic int frame_pix(input int h_res, input int v_res);
    return h_res * v_res;
  endfunction

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/color_frame_sched_counter.sv
// -----------------------------------------------------------------------------
// frame_pix_counter
//   Counts accepted pixel beats within one frame and flags the last pixel.
//   Wraps to 0 after the last beat so it is ready for the next frame.
// Ports
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   clr   in  synchronous clear (start of a frame); wins over en
//   en    in  one accepted beat this cycle
//   last  out current count is N-1, i.e. the next beat ends the frame
// -----------------------------------------------------------------------------
module frame_pix_counter
  import color_sched_pkg::*;
#(
  parameter int N = 8,
  parameter int W = cnt_width(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last = (cnt_q == W'(N - 1));

  // NOTE: the next-state value is assigned first on every path through the
  // block, so no branch leaves cnt_d unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop in the
  // design samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/color_frame_sched.sv
// -----------------------------------------------------------------------------
// color_frame_sched
//   Frame sequencer for the HSV colour-pixel separator. Feeds one RGB pixel per
//   accepted beat to the separator, clears its colour count before the frame,
//   flushes its pipeline after the frame, captures the count, compares it to a
//   threshold and reports one result per frame over a valid/ack handshake.
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start, thr           begin a frame / colour-pixel threshold (sampled on start)
//   busy                 sequencer not idle
//   pix_valid/pix_ready  input pixel handshake; pix_r/g/b pixel data
//   sep_frameclk         separator count clear, active low
//   sep_ri/gi/bi         registered pixel to separator, zero on idle cycles
//   sep_qtd              separator colour-pixel count
//   res_valid/res_ack    result handshake
//   res_count, res_hit   captured count and (count >= thr)
//   frame_no             index of the reported frame, wrapping
// -----------------------------------------------------------------------------
module color_frame_sched
  import color_sched_pkg::*;
#(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int SEP_LAT = SEP_LAT_DEF,
  parameter int CNT_W   = 32,
  parameter int FNO_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] thr,
  output logic             busy,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       pix_r,
  input  logic [7:0]       pix_g,
  input  logic [7:0]       pix_b,
  output logic             sep_frameclk,
  output logic [7:0]       sep_ri,
  output logic [7:0]       sep_gi,
  output logic [7:0]       sep_bi,
  input  logic [CNT_W-1:0] sep_qtd,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [CNT_W-1:0] res_count,
  output logic             res_hit,
  output logic [FNO_W-1:0] frame_no
);

  localparam int FRAME_PIX = frame_pix(H_RES, V_RES);
  // Flush counter spans 0..SEP_LAT, used for both CLEAR and DRAIN.
  localparam int FL_W      = cnt_width(SEP_LAT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   thr_q, thr_d;
  logic [FL_W-1:0]    flush_q, flush_d;
  logic [FNO_W-1:0]   frame_no_q, frame_no_d;
  logic               res_valid_q, res_valid_d;
  logic [CNT_W-1:0]   res_count_q, res_count_d;
  logic               res_hit_q, res_hit_d;
  logic               pix_ready_q, pix_ready_d;
  logic               sep_frameclk_q, sep_frameclk_d;
  logic               busy_q, busy_d;
  logic [7:0]         sep_r_q, sep_r_d;
  logic [7:0]         sep_g_q, sep_g_d;
  logic [7:0]         sep_b_q, sep_b_d;

  logic               beat;
  logic               pix_last;
  logic               cnt_clr;
  logic               flush_done;

  assign beat       = pix_valid & pix_ready_q;
  assign flush_done = (flush_q == FL_W'(SEP_LAT));

  frame_pix_counter #(
    .N (FRAME_PIX)
  ) u_pix_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (beat),
    .last (pix_last)
  );

  always_comb begin
    state_d     = state_q;
    thr_d       = thr_q;
    flush_d     = flush_q;
    frame_no_d  = frame_no_q;
    res_valid_d = res_valid_q;
    res_count_d = res_count_q;
    res_hit_d   = res_hit_q;
    cnt_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          thr_d   = thr;
          flush_d = '0;
          cnt_clr = 1'b1;
        end
      end

      // Separator count held cleared while zeros push out any stale h/s/v.
      CLEAR: begin
        if (flush_done) begin
          state_d = STREAM;
          flush_d = '0;
        end else begin
          flush_d = flush_q + FL_W'(1);
        end
      end

      STREAM: begin
        if (beat && pix_last) begin
          state_d = DRAIN;
          flush_d = '0;
        end
      end

      // Wait for the last pixel to reach pixqtd before sampling it.
      DRAIN: begin
        if (flush_done) begin
          state_d = CAPTURE;
          flush_d = '0;
        end else begin
          flush_d = flush_q + FL_W'(1);
        end
      end

      CAPTURE: begin
        res_count_d = sep_qtd;
        res_hit_d   = (sep_qtd >= thr_q);
        res_valid_d = 1'b1;
        state_d     = REPORT;
      end

      REPORT: begin
        if (res_ack) begin
          res_valid_d = 1'b0;
          frame_no_d  = frame_no_q + FNO_W'(1);
          if (start) begin
            state_d = CLEAR;
            thr_d   = thr;
            flush_d = '0;
            cnt_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs registered from the next state so they line up with state_q.
    pix_ready_d    = (state_d == STREAM);
    sep_frameclk_d = !(state_d inside {IDLE, CLEAR});
    busy_d         = (state_d != IDLE);

    // Bubbles are fed as black, which the separator never counts.
    sep_r_d = beat ? pix_r : 8'd0;
    sep_g_d = beat ? pix_g : 8'd0;
    sep_b_d = beat ? pix_b : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      thr_q          <= '0;
      flush_q        <= '0;
      frame_no_q     <= '0;
      res_valid_q    <= 1'b0;
      res_count_q    <= '0;
      res_hit_q      <= 1'b0;
      pix_ready_q    <= 1'b0;
      sep_frameclk_q <= 1'b0;
      busy_q         <= 1'b0;
      sep_r_q        <= 8'd0;
      sep_g_q        <= 8'd0;
      sep_b_q        <= 8'd0;
    end else begin
      state_q        <= state_d;
      thr_q          <= thr_d;
      flush_q        <= flush_d;
      frame_no_q     <= frame_no_d;
      res_valid_q    <= res_valid_d;
      res_count_q    <= res_count_d;
      res_hit_q      <= res_hit_d;
      pix_ready_q    <= pix_ready_d;
      sep_frameclk_q <= sep_frameclk_d;
      busy_q         <= busy_d;
      sep_r_q        <= sep_r_d;
      sep_g_q        <= sep_g_d;
      sep_b_q        <= sep_b_d;
    end
  end

  assign busy         = busy_q;
  assign pix_ready    = pix_ready_q;
  assign sep_frameclk = sep_frameclk_q;
  assign sep_ri       = sep_r_q;
  assign sep_gi       = sep_g_q;
  assign sep_bi       = sep_b_q;
  assign res_valid    = res_valid_q;
  assign res_count    = res_count_q;
  assign res_hit      = res_hit_q;
  assign frame_no     = frame_no_q;

endmodule
